// File: rtl/rs_age_issue.sv
// Age-ordered reservation station: holds dispatched ALU instructions until both
// operands arrive on any writeback channel, then issues the oldest ready entry.
module rs_age_issue #(
  parameter int DEPTH   = 16,
  parameter int NWB     = 2,
  parameter int DAT_W   = 32,
  parameter int OP_W    = 6,
  parameter int ROB_BIT = 4,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush_i,
  input  logic                   disp_en_i,
  input  logic [OP_W-1:0]        disp_op_i,
  input  logic                   disp_ic_i,
  input  logic [ROB_BIT-1:0]     disp_qj_i,
  input  logic [ROB_BIT-1:0]     disp_qk_i,
  input  logic [DAT_W-1:0]       disp_vj_i,
  input  logic [DAT_W-1:0]       disp_vk_i,
  input  logic [ROB_BIT-1:0]     disp_qd_i,
  input  logic [DAT_W-1:0]       disp_imm_i,
  input  logic [DAT_W-1:0]       disp_pc_i,
  input  logic [NWB-1:0]         wb_en_i,
  input  logic [NWB*ROB_BIT-1:0] wb_q_i,
  input  logic [NWB*DAT_W-1:0]   wb_v_i,
  output logic                   alu_valid_o,
  input  logic                   alu_ready_i,
  output logic [OP_W-1:0]        alu_op_o,
  output logic                   alu_ic_o,
  output logic [ROB_BIT-1:0]     alu_qd_o,
  output logic [DAT_W-1:0]       alu_vs_o,
  output logic [DAT_W-1:0]       alu_vt_o,
  output logic [DAT_W-1:0]       alu_imm_o,
  output logic [DAT_W-1:0]       alu_pc_o,
  output logic                   full_o,
  output logic [CNT_W-1:0]       cnt_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic                busy_q [DEPTH];
  logic                busy_d [DEPTH];
  logic [OP_W-1:0]     op_q   [DEPTH];
  logic [OP_W-1:0]     op_d   [DEPTH];
  logic                ic_q   [DEPTH];
  logic                ic_d   [DEPTH];
  logic [ROB_BIT-1:0]  qj_q   [DEPTH];
  logic [ROB_BIT-1:0]  qj_d   [DEPTH];
  logic [ROB_BIT-1:0]  qk_q   [DEPTH];
  logic [ROB_BIT-1:0]  qk_d   [DEPTH];
  logic [DAT_W-1:0]    vj_q   [DEPTH];
  logic [DAT_W-1:0]    vj_d   [DEPTH];
  logic [DAT_W-1:0]    vk_q   [DEPTH];
  logic [DAT_W-1:0]    vk_d   [DEPTH];
  logic [ROB_BIT-1:0]  qd_q   [DEPTH];
  logic [ROB_BIT-1:0]  qd_d   [DEPTH];
  logic [DAT_W-1:0]    imm_q  [DEPTH];
  logic [DAT_W-1:0]    imm_d  [DEPTH];
  logic [DAT_W-1:0]    pc_q   [DEPTH];
  logic [DAT_W-1:0]    pc_d   [DEPTH];
  // age_q[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0]    age_q  [DEPTH];
  logic [DEPTH-1:0]    age_d  [DEPTH];

  logic                lock_q, lock_d;
  logic [IDX_W-1:0]    lock_idx_q, lock_idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [DEPTH-1:0]    ready;
  logic [IDX_W-1:0]    oldest_idx;
  logic [IDX_W-1:0]    free_idx;
  logic [IDX_W-1:0]    sel_idx;
  logic                any_ready;
  logic                disp_take;
  logic                issue_fire;

  // Lowest channel wins on duplicate tags, so scan from the top and let lower indices overwrite.
  function automatic logic [DAT_W:0] wake(input logic [ROB_BIT-1:0] tag,
                                          input logic [DAT_W-1:0] cur,
                                          input logic [NWB-1:0] ben,
                                          input logic [NWB*ROB_BIT-1:0] bq,
                                          input logic [NWB*DAT_W-1:0] bv);
    logic             hit;
    logic [DAT_W-1:0] val;
    hit = 1'b0;
    val = cur;
    for (int c = NWB - 1; c >= 0; c--) begin
      if (ben[c] && bq[c*ROB_BIT +: ROB_BIT] != '0 && bq[c*ROB_BIT +: ROB_BIT] == tag) begin
        hit = 1'b1;
        val = bv[c*DAT_W +: DAT_W];
      end
    end
    return {hit, val};
  endfunction

  always_comb begin
    ready      = '0;
    oldest_idx = '0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy_q[i] && qj_q[i] == '0 && qk_q[i] == '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      logic older_ready;
      older_ready = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready[j] && age_q[j][i]) older_ready = 1'b1;
      end
      if (ready[i] && !older_ready) oldest_idx = IDX_W'(i);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign any_ready   = |ready;
  assign sel_idx     = lock_q ? lock_idx_q : oldest_idx;
  assign full_o      = cnt_q == CNT_W'(DEPTH);
  assign cnt_o       = cnt_q;
  assign alu_valid_o = en && !flush_i && !rst && (lock_q || any_ready);
  assign disp_take   = en && disp_en_i && !full_o && !flush_i && !rst;
  assign issue_fire  = alu_valid_o && alu_ready_i;

  always_comb begin
    alu_op_o  = '0;
    alu_ic_o  = 1'b0;
    alu_qd_o  = '0;
    alu_vs_o  = '0;
    alu_vt_o  = '0;
    alu_imm_o = '0;
    alu_pc_o  = '0;
    if (alu_valid_o) begin
      alu_op_o  = op_q[sel_idx];
      alu_ic_o  = ic_q[sel_idx];
      alu_qd_o  = qd_q[sel_idx];
      alu_vs_o  = vj_q[sel_idx];
      alu_vt_o  = vk_q[sel_idx];
      alu_imm_o = imm_q[sel_idx];
      alu_pc_o  = pc_q[sel_idx];
    end
  end

  always_comb begin
    logic [DAT_W:0] wj;
    logic [DAT_W:0] wk;
    for (int i = 0; i < DEPTH; i++) begin
      busy_d[i] = busy_q[i];
      op_d[i]   = op_q[i];
      ic_d[i]   = ic_q[i];
      qj_d[i]   = qj_q[i];
      qk_d[i]   = qk_q[i];
      vj_d[i]   = vj_q[i];
      vk_d[i]   = vk_q[i];
      qd_d[i]   = qd_q[i];
      imm_d[i]  = imm_q[i];
      pc_d[i]   = pc_q[i];
      age_d[i]  = age_q[i];
    end
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    cnt_d      = cnt_q;
    wj         = '0;
    wk         = '0;

    if (en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i]) begin
          wj = wake(qj_q[i], vj_q[i], wb_en_i, wb_q_i, wb_v_i);
          wk = wake(qk_q[i], vk_q[i], wb_en_i, wb_q_i, wb_v_i);
          if (wj[DAT_W]) begin
            qj_d[i] = '0;
            vj_d[i] = wj[DAT_W-1:0];
          end
          if (wk[DAT_W]) begin
            qk_d[i] = '0;
            vk_d[i] = wk[DAT_W-1:0];
          end
        end
      end

      // A dispatch sees the same broadcasts, so a producer finishing this cycle is not missed.
      if (disp_take) begin
        wj = wake(disp_qj_i, disp_vj_i, wb_en_i, wb_q_i, wb_v_i);
        wk = wake(disp_qk_i, disp_vk_i, wb_en_i, wb_q_i, wb_v_i);
        busy_d[free_idx] = 1'b1;
        op_d[free_idx]   = disp_op_i;
        ic_d[free_idx]   = disp_ic_i;
        qd_d[free_idx]   = disp_qd_i;
        imm_d[free_idx]  = disp_imm_i;
        pc_d[free_idx]   = disp_pc_i;
        qj_d[free_idx]   = wj[DAT_W] ? '0 : disp_qj_i;
        vj_d[free_idx]   = wj[DAT_W-1:0];
        qk_d[free_idx]   = wk[DAT_W] ? '0 : disp_qk_i;
        vk_d[free_idx]   = wk[DAT_W-1:0];
        age_d[free_idx]  = '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (IDX_W'(j) != free_idx) age_d[j][free_idx] = 1'b1;
        end
      end

      if (issue_fire) begin
        busy_d[sel_idx] = 1'b0;
        lock_d          = 1'b0;
      end else if (alu_valid_o) begin
        lock_d     = 1'b1;
        lock_idx_d = sel_idx;
      end

      cnt_d = cnt_q + CNT_W'(disp_take) - CNT_W'(issue_fire);

      if (flush_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          busy_d[i] = 1'b0;
          qj_d[i]   = '0;
          qk_d[i]   = '0;
        end
        lock_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i] <= 1'b0;
        op_q[i]   <= '0;
        ic_q[i]   <= 1'b0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        qd_q[i]   <= '0;
        imm_q[i]  <= '0;
        pc_q[i]   <= '0;
        age_q[i]  <= '0;
      end
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i] <= busy_d[i];
        op_q[i]   <= op_d[i];
        ic_q[i]   <= ic_d[i];
        qj_q[i]   <= qj_d[i];
        qk_q[i]   <= qk_d[i];
        vj_q[i]   <= vj_d[i];
        vk_q[i]   <= vk_d[i];
        qd_q[i]   <= qd_d[i];
        imm_q[i]  <= imm_d[i];
        pc_q[i]   <= pc_d[i];
        age_q[i]  <= age_d[i];
      end
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rs_age_issue.sv
// Directed bench for rs_age_issue: hand-computed vectors covering issue order,
// wakeup, backpressure lock, full handling, flush and global enable.
module tb_rs_age_issue;

  localparam int DEPTH   = 16;
  localparam int NWB     = 2;
  localparam int DAT_W   = 32;
  localparam int OP_W    = 6;
  localparam int ROB_BIT = 4;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en;
  logic                   flush_i;
  logic                   disp_en_i;
  logic [OP_W-1:0]        disp_op_i;
  logic                   disp_ic_i;
  logic [ROB_BIT-1:0]     disp_qj_i;
  logic [ROB_BIT-1:0]     disp_qk_i;
  logic [DAT_W-1:0]       disp_vj_i;
  logic [DAT_W-1:0]       disp_vk_i;
  logic [ROB_BIT-1:0]     disp_qd_i;
  logic [DAT_W-1:0]       disp_imm_i;
  logic [DAT_W-1:0]       disp_pc_i;
  logic [NWB-1:0]         wb_en_i;
  logic [NWB*ROB_BIT-1:0] wb_q_i;
  logic [NWB*DAT_W-1:0]   wb_v_i;
  logic                   alu_valid_o;
  logic                   alu_ready_i;
  logic [OP_W-1:0]        alu_op_o;
  logic                   alu_ic_o;
  logic [ROB_BIT-1:0]     alu_qd_o;
  logic [DAT_W-1:0]       alu_vs_o;
  logic [DAT_W-1:0]       alu_vt_o;
  logic [DAT_W-1:0]       alu_imm_o;
  logic [DAT_W-1:0]       alu_pc_o;
  logic                   full_o;
  logic [CNT_W-1:0]       cnt_o;

  int testCount = 0;
  int failCount = 0;

  rs_age_issue #(
    .DEPTH(DEPTH), .NWB(NWB), .DAT_W(DAT_W), .OP_W(OP_W), .ROB_BIT(ROB_BIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .flush_i(flush_i),
    .disp_en_i(disp_en_i), .disp_op_i(disp_op_i), .disp_ic_i(disp_ic_i),
    .disp_qj_i(disp_qj_i), .disp_qk_i(disp_qk_i),
    .disp_vj_i(disp_vj_i), .disp_vk_i(disp_vk_i),
    .disp_qd_i(disp_qd_i), .disp_imm_i(disp_imm_i), .disp_pc_i(disp_pc_i),
    .wb_en_i(wb_en_i), .wb_q_i(wb_q_i), .wb_v_i(wb_v_i),
    .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
    .alu_op_o(alu_op_o), .alu_ic_o(alu_ic_o), .alu_qd_o(alu_qd_o),
    .alu_vs_o(alu_vs_o), .alu_vt_o(alu_vt_o), .alu_imm_o(alu_imm_o), .alu_pc_o(alu_pc_o),
    .full_o(full_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Dispatch and broadcast inputs last one cycle; en and alu_ready_i persist.
  task automatic tick();
    @(posedge clk);
    #1;
    disp_en_i = 1'b0;
    wb_en_i   = '0;
    wb_q_i    = '0;
    wb_v_i    = '0;
    flush_i   = 1'b0;
  endtask

  task automatic applyStimulus(input logic [OP_W-1:0] op, input logic [ROB_BIT-1:0] qj,
                               input logic [ROB_BIT-1:0] qk, input logic [DAT_W-1:0] vj,
                               input logic [DAT_W-1:0] vk, input logic [ROB_BIT-1:0] qd);
    disp_en_i  = 1'b1;
    disp_op_i  = op;
    disp_ic_i  = 1'b1;
    disp_qj_i  = qj;
    disp_qk_i  = qk;
    disp_vj_i  = vj;
    disp_vk_i  = vk;
    disp_qd_i  = qd;
    disp_imm_i = 32'h100 + DAT_W'(qd);
    disp_pc_i  = 32'h4000 + DAT_W'(qd);
  endtask

  task automatic bcast(input int ch, input logic [ROB_BIT-1:0] tag, input logic [DAT_W-1:0] val);
    wb_en_i[ch]                 = 1'b1;
    wb_q_i[ch*ROB_BIT +: ROB_BIT] = tag;
    wb_v_i[ch*DAT_W +: DAT_W]     = val;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; flush_i = 1'b0; disp_en_i = 1'b0; alu_ready_i = 1'b0;
    disp_op_i = '0; disp_ic_i = 1'b0; disp_qj_i = '0; disp_qk_i = '0;
    disp_vj_i = '0; disp_vk_i = '0; disp_qd_i = '0; disp_imm_i = '0; disp_pc_i = '0;
    wb_en_i = '0; wb_q_i = '0; wb_v_i = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("reset_valid", alu_valid_o, 0);
    checkOutput("reset_cnt", cnt_o, 0);
    checkOutput("reset_full", full_o, 0);
    checkOutput("reset_vs", alu_vs_o, 0);
    checkOutput("reset_qd", alu_qd_o, 0);

    // Simple ready ADD
    alu_ready_i = 1'b1;
    applyStimulus(6'd1, 0, 0, 5, 7, 3);
    tick();
    #1;
    checkOutput("add_cnt1", cnt_o, 1);
    checkOutput("add_valid", alu_valid_o, 1);
    checkOutput("add_vs", alu_vs_o, 5);
    checkOutput("add_vt", alu_vt_o, 7);
    checkOutput("add_qd", alu_qd_o, 3);
    checkOutput("add_op", alu_op_o, 1);
    checkOutput("add_imm", alu_imm_o, 32'h103);
    tick();
    #1;
    checkOutput("add_cnt0", cnt_o, 0);
    checkOutput("add_idle", alu_valid_o, 0);

    // Older waiting entry, younger ready entry issues first
    applyStimulus(6'd2, 2, 0, 0, 1, 5);
    tick();
    applyStimulus(6'd3, 0, 0, 32'h20, 32'h21, 6);
    tick();
    bcast(1, 2, 32'h11);
    #1;
    checkOutput("b_first_valid", alu_valid_o, 1);
    checkOutput("b_first_qd", alu_qd_o, 6);
    tick();
    #1;
    checkOutput("a_next_valid", alu_valid_o, 1);
    checkOutput("a_next_qd", alu_qd_o, 5);
    checkOutput("a_next_vs", alu_vs_o, 32'h11);
    tick();
    #1;
    checkOutput("ab_empty", cnt_o, 0);

    // Dispatch coincident with producer broadcast; lower channel wins
    applyStimulus(6'd4, 0, 4, 3, 0, 7);
    bcast(0, 4, 9);
    bcast(1, 4, 32'hAA);
    tick();
    #1;
    checkOutput("coinc_valid", alu_valid_o, 1);
    checkOutput("coinc_vt", alu_vt_o, 9);
    checkOutput("coinc_qd", alu_qd_o, 7);
    tick();
    #1;
    checkOutput("coinc_cnt", cnt_o, 0);

    // Selection lock: an older entry waking later must not displace the presented one
    alu_ready_i = 1'b0;
    applyStimulus(6'd5, 7, 0, 0, 2, 10);
    tick();
    applyStimulus(6'd6, 0, 0, 32'h40, 0, 11);
    tick();
    #1;
    checkOutput("lock_pres_qd", alu_qd_o, 11);
    tick();
    bcast(0, 7, 32'h77);
    #1;
    checkOutput("lock_bc_qd", alu_qd_o, 11);
    tick();
    #1;
    checkOutput("lock_hold_qd", alu_qd_o, 11);
    alu_ready_i = 1'b1;
    #1;
    checkOutput("lock_accept_qd", alu_qd_o, 11);
    tick();
    #1;
    checkOutput("lock_older_qd", alu_qd_o, 10);
    checkOutput("lock_older_vs", alu_vs_o, 32'h77);
    tick();
    #1;
    checkOutput("lock_empty_valid", alu_valid_o, 0);
    checkOutput("lock_empty_cnt", cnt_o, 0);

    // Fill all entries under backpressure
    alu_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(OP_W'(i), 0, 0, DAT_W'(100 + i), DAT_W'(i), ROB_BIT'(i % 15 + 1));
      tick();
    end
    #1;
    checkOutput("fill_full", full_o, 1);
    checkOutput("fill_cnt", cnt_o, DEPTH);
    checkOutput("fill_valid", alu_valid_o, 1);
    checkOutput("fill_vs", alu_vs_o, 100);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(6'd63, 0, 0, 999, 999, 15);
      bcast(1, 0, 32'hBAD);
      #1;
      checkOutput("full_hold_vs", alu_vs_o, 100);
      tick();
      #1;
      checkOutput("full_hold_cnt", cnt_o, DEPTH);
    end
    applyStimulus(6'd63, 0, 0, 999, 999, 15);
    alu_ready_i = 1'b1;
    #1;
    checkOutput("drain0_vs", alu_vs_o, 100);
    tick();
    #1;
    checkOutput("full_issue_nodisp", cnt_o, DEPTH - 1);
    for (int i = 1; i < DEPTH; i++) begin
      checkOutput("drain_valid", alu_valid_o, 1);
      checkOutput("drain_vs", alu_vs_o, 100 + i);
      checkOutput("drain_cnt", cnt_o, DEPTH - i);
      tick();
      #1;
    end
    checkOutput("drain_done_valid", alu_valid_o, 0);
    checkOutput("drain_done_cnt", cnt_o, 0);

    // Flush with dispatch and ready ALU in the same cycle
    alu_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(6'd9, 0, 0, DAT_W'(i), 0, ROB_BIT'(i + 1));
      tick();
    end
    #1;
    checkOutput("pre_flush_cnt", cnt_o, 5);
    applyStimulus(6'd9, 0, 0, 6, 0, 6);
    flush_i = 1'b1;
    alu_ready_i = 1'b1;
    #1;
    checkOutput("flush_cyc_valid", alu_valid_o, 0);
    tick();
    #1;
    checkOutput("flush_cnt", cnt_o, 0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("flush_no_issue", alu_valid_o, 0);
      tick();
      #1;
    end
    applyStimulus(6'd10, 0, 0, 32'h99, 0, 9);
    tick();
    #1;
    checkOutput("post_flush_cnt", cnt_o, 1);
    checkOutput("post_flush_qd", alu_qd_o, 9);
    checkOutput("post_flush_vs", alu_vs_o, 32'h99);
    tick();
    #1;
    checkOutput("post_flush_empty", cnt_o, 0);

    // Global enable low freezes everything and drops broadcasts
    alu_ready_i = 1'b0;
    applyStimulus(6'd11, 0, 0, 32'h31, 0, 1);
    tick();
    applyStimulus(6'd12, 9, 0, 0, 0, 2);
    tick();
    en = 1'b0;
    alu_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bcast(0, 9, 32'h55);
      applyStimulus(6'd13, 0, 0, 0, 0, 3);
      #1;
      checkOutput("en0_valid", alu_valid_o, 0);
      tick();
    end
    en = 1'b1;
    #1;
    checkOutput("en1_cnt", cnt_o, 2);
    checkOutput("en1_valid", alu_valid_o, 1);
    checkOutput("en1_qd", alu_qd_o, 1);
    checkOutput("en1_vs", alu_vs_o, 32'h31);
    tick();
    #1;
    checkOutput("en1_lost_wake", alu_valid_o, 0);
    checkOutput("en1_cnt1", cnt_o, 1);
    bcast(0, 9, 32'h66);
    tick();
    #1;
    checkOutput("en1_wake_valid", alu_valid_o, 1);
    checkOutput("en1_wake_qd", alu_qd_o, 2);
    checkOutput("en1_wake_vs", alu_vs_o, 32'h66);
    tick();
    #1;
    checkOutput("en1_final_cnt", cnt_o, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
